// File: rtl/audio_seq_pkg.sv
// Shared types for the audio stream sequencer: FSM states, stereo sample, counter limit.
// No logic of its own; imported by the sequencer and its FIFO.
// Saturating increment helper keeps the counters from wrapping.
package audio_seq_pkg;

    localparam int DW = 24;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } seq_state_t;

    typedef struct packed {
        logic [DW-1:0] left;
        logic [DW-1:0] right;
    } stereo_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic inc);
        return (inc && (value != COUNT_MAX)) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/stereo_fifo.sv
// Elastic stereo sample FIFO with synchronous flush and an explicit occupancy count.
// Latency: a pushed sample is visible at head on the next cycle; head reads combinationally.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module stereo_fifo
    import audio_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  stereo_t       push_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output stereo_t       head
);

    localparam int LW = AW + 1;

    stereo_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the push lands in, so full+pop+push is a legal transfer.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/audio_stream_sequencer.sv
// Decouples codec ADC reads from DAC writes through an elastic FIFO, pre-filling before draining.
// Latency: ADC sample reaches the DAC no earlier than one cycle after capture; read/write are combinational.
// Backpressure: read/write simply qualify read_ready/write_ready; FIFO-full drops and counts, empty plays silence.
module audio_stream_sequencer
    import audio_seq_pkg::*;
#(
    parameter int DW    = 24,
    parameter int DEPTH = 8,
    parameter int PRIME = 4,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          enable,
    input  logic          mute,
    input  logic          read_ready,
    input  logic [DW-1:0] readdata_left,
    input  logic [DW-1:0] readdata_right,
    input  logic          write_ready,
    output logic          read,
    output logic          write,
    output logic [DW-1:0] writedata_left,
    output logic [DW-1:0] writedata_right,
    output logic [LW-1:0] fifo_level,
    output logic [15:0]   overrun_count,
    output logic [15:0]   underrun_count
);

    seq_state_t    state;
    seq_state_t    state_nxt;
    stereo_t       push_dat;
    stereo_t       head;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          pop;
    logic          flush;
    logic          underrun;
    logic          overrun;

    assign push_dat   = '{left: readdata_left, right: readdata_right};
    assign flush      = ~enable;
    assign fifo_level = level;
    // Codec FIFO keeps moving even when ours is full; the sample is dropped and counted.
    assign overrun    = read & full & ~pop;

    stereo_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (CLOCK_50),
        .rst      (reset),
        .push     (read),
        .pop      (pop),
        .flush    (flush),
        .push_dat (push_dat),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .head     (head)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        read            = 1'b0;
        write           = 1'b0;
        writedata_left  = '0;
        writedata_right = '0;
        pop             = 1'b0;
        underrun        = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = FILL;
            end
            FILL: begin
                read  = read_ready;
                write = write_ready;
                if (!enable)                   state_nxt = IDLE;
                else if (level >= LW'(PRIME)) state_nxt = RUN;
            end
            RUN: begin
                read  = read_ready;
                write = write_ready;
                if (!empty) begin
                    pop = write_ready;
                    if (!mute) begin
                        writedata_left  = head.left;
                        writedata_right = head.right;
                    end
                end else if (write_ready) begin
                    // Starved: play one silent sample and re-prime before draining again.
                    underrun  = 1'b1;
                    state_nxt = FILL;
                end
                if (!enable) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            read  = 1'b0;
            write = 1'b0;
            pop   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            overrun_count  <= '0;
            underrun_count <= '0;
        end else begin
            overrun_count  <= sat_inc(overrun_count, overrun);
            underrun_count <= sat_inc(underrun_count, underrun);
        end
    end

endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Directed bench for audio_stream_sequencer with a sample scoreboard queue.
// Expected samples are queued on capture and compared when the DAC write drains them.
module tb_audio_stream_sequencer;
    import audio_seq_pkg::*;

    localparam int TDW    = 24;
    localparam int TDEPTH = 8;
    localparam int TPRIME = 4;
    localparam int TLW    = $clog2(TDEPTH) + 1;

    logic           CLOCK_50 = 1'b0;
    logic           reset;
    logic           enable;
    logic           mute;
    logic           read_ready;
    logic [TDW-1:0] readdata_left;
    logic [TDW-1:0] readdata_right;
    logic           write_ready;
    logic           read;
    logic           write;
    logic [TDW-1:0] writedata_left;
    logic [TDW-1:0] writedata_right;
    logic [TLW-1:0] fifo_level;
    logic [15:0]    overrun_count;
    logic [15:0]    underrun_count;

    int checks   = 0;
    int failures = 0;

    seq_state_t ms;
    stereo_t    mq[$];
    int         m_ovr;
    int         m_und;
    logic [TDW-1:0] obs_wl;
    logic [TDW-1:0] obs_wr;
    logic           obs_rd;
    int             rd_cnt;
    int             k;

    audio_stream_sequencer #(
        .DW    (TDW),
        .DEPTH (TDEPTH),
        .PRIME (TPRIME)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .enable          (enable),
        .mute            (mute),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .write_ready     (write_ready),
        .read            (read),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .fifo_level      (fifo_level),
        .overrun_count   (overrun_count),
        .underrun_count  (underrun_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        ms    = IDLE;
        mq.delete();
        m_ovr = 0;
        m_und = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model mid-cycle, advance the model.
    task automatic cyc(input logic en, input logic rr, input logic wr, input logic mu,
                       input logic [TDW-1:0] l, input logic [TDW-1:0] r);
        logic           e_rd;
        logic           e_wr;
        logic [TDW-1:0] e_l;
        logic [TDW-1:0] e_r;
        logic           do_pop;
        logic           acc;
        logic           und;
        int             sz;
        stereo_t        s;
        enable         = en;
        read_ready     = rr;
        write_ready    = wr;
        mute           = mu;
        readdata_left  = l;
        readdata_right = r;
        @(negedge CLOCK_50);
        sz   = mq.size();
        e_rd = (ms != IDLE) && rr;
        e_wr = (ms != IDLE) && wr;
        e_l  = '0;
        e_r  = '0;
        if (ms == RUN && sz > 0 && !mu) begin
            e_l = mq[0].left;
            e_r = mq[0].right;
        end
        chk("read", 32'(read), 32'(e_rd));
        chk("write", 32'(write), 32'(e_wr));
        if (e_wr) begin
            chk("wd_left", 32'(writedata_left), 32'(e_l));
            chk("wd_right", 32'(writedata_right), 32'(e_r));
        end
        chk("level", 32'(fifo_level), 32'(sz));
        chk("overrun_count", 32'(overrun_count), 32'(m_ovr));
        chk("underrun_count", 32'(underrun_count), 32'(m_und));
        chk("state", 32'(dut.state), 32'(ms));
        obs_wl = writedata_left;
        obs_wr = writedata_right;
        obs_rd = read;
        do_pop = (ms == RUN) && wr && (sz > 0);
        acc    = e_rd && ((sz < TDEPTH) || do_pop);
        und    = (ms == RUN) && wr && (sz == 0);
        if (e_rd && !acc) m_ovr++;
        if (und) m_und++;
        @(posedge CLOCK_50);
        if (do_pop) void'(mq.pop_front());
        if (acc) begin
            s.left  = l;
            s.right = r;
            mq.push_back(s);
        end
        case (ms)
            IDLE: if (en) ms = FILL;
            FILL: if (!en) ms = IDLE; else if (sz >= TPRIME) ms = RUN;
            RUN:  if (!en) ms = IDLE; else if (und) ms = FILL;
            default: ms = IDLE;
        endcase
        if (!en) mq.delete();
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        mute           = 1'b0;
        read_ready     = 1'b0;
        write_ready    = 1'b0;
        readdata_left  = '0;
        readdata_right = '0;
        k              = 0;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1 reset = 1'b0;

        // Idle after reset: ready inputs must not produce handshakes.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 24'h0);
        chk("reset_level", 32'(fifo_level), 32'd0);
        chk("reset_ovr", 32'(overrun_count), 32'd0);

        // Prime: four captures while the DAC is fed silence.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 24'h123456, 24'hABCDEF);
        for (int i = 1; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 24'h100000 + 24'(i), 24'h200000 + 24'(i));
        chk("prime_level", 32'(fifo_level), 32'd4);
        chk("prime_still_fill", 32'(dut.state), 32'(FILL));
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
        chk("prime_run", 32'(dut.state), 32'(RUN));
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
        chk("first_left", 32'(obs_wl), 32'h123456);
        chk("first_right", 32'(obs_wr), 32'hABCDEF);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
        chk("drained", 32'(fifo_level), 32'd0);

        // Overrun: ten captures into an eight-deep FIFO with the DAC stalled.
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 24'h300000 + 24'(i), 24'h400000 + 24'(i));
            if (obs_rd) rd_cnt++;
        end
        chk("ovr_level", 32'(fifo_level), 32'd8);
        chk("ovr_count", 32'(overrun_count), 32'd2);
        chk("ovr_read_pulses", 32'(rd_cnt), 32'd10);

        // Full with simultaneous push and pop: no overrun, oldest sample leaves first.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 24'h500000, 24'h600000);
        chk("full_pp_head", 32'(obs_wl), 32'h300000);
        for (int i = 1; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 24'h500000 + 24'(i), 24'h600000 + 24'(i));
        chk("full_pp_level", 32'(fifo_level), 32'd8);
        chk("full_pp_ovr", 32'(overrun_count), 32'd2);

        // Mute: silence out, FIFO still drains one per write.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 24'h0, 24'h0);
        chk("mute_data", 32'(obs_wl), 32'd0);
        chk("mute_level", 32'(fifo_level), 32'd1);

        // Underrun: last stored sample, then one silent sample and back to FILL.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
        chk("last_sample", 32'(obs_wl), 32'h500002);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
        chk("und_data", 32'(obs_wl), 32'd0);
        chk("und_count", 32'(underrun_count), 32'd1);
        chk("und_state", 32'(dut.state), 32'(FILL));

        // Disable: park in IDLE, flush, keep the counters.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 24'h700000, 24'h800000);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 24'h700001, 24'h800001);
        chk("dis_state", 32'(dut.state), 32'(IDLE));
        chk("dis_level", 32'(fifo_level), 32'd0);
        chk("dis_ovr", 32'(overrun_count), 32'd2);
        chk("dis_und", 32'(underrun_count), 32'd1);

        // Reset mid-stream with five samples queued in RUN.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        for (int i = 0; i < 5; i++) begin
            k = i;
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 24'h900000 + 24'(k), 24'hA00000 + 24'(k));
        end
        chk("pre_rst_level", 32'(fifo_level), 32'd5);
        chk("pre_rst_state", 32'(dut.state), 32'(RUN));
        read_ready  = 1'b1;
        write_ready = 1'b1;
        reset       = 1'b1;
        #1;
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        @(posedge CLOCK_50);
        #1;
        enable = 1'b0;
        reset  = 1'b0;
        model_reset();
        #1;
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovr", 32'(overrun_count), 32'd0);
        chk("rst_und", 32'(underrun_count), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 24'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_stream_sequencer.md
Name: audio_stream_sequencer

Overview:
Sequences the read/write handshakes of the audio_codec so that ADC-to-DAC sample transfer is decoupled by an elastic stereo FIFO, instead of being tied by a direct read_ready & write_ready loop. It pre-fills the FIFO before draining and feeds silence while not streaming. It also counts overruns and underruns. It sits between audio_codec and the top level, replacing the direct loop-back wiring.

Parameters:
DW, 24, sample width per channel; must match the codec data width.
DEPTH, 8, FIFO depth in stereo samples; power of 2, at least 4.
PRIME, 4, FIFO level required before draining starts; 1 <= PRIME <= DEPTH.

Ports:
CLOCK_50  in  1  system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
enable  in  1  streaming enable; low flushes the FIFO and parks the block.
mute  in  1  while high, DAC data is forced to 0; FIFO still drains.
read_ready  in  1  codec ADC FIFO has a sample.
readdata_left  in  DW  codec ADC left sample.
readdata_right  in  DW  codec ADC right sample.
write_ready  in  1  codec DAC FIFO has space.
read  out  1  pop one stereo sample from the codec ADC FIFO.
write  out  1  push one stereo sample to the codec DAC FIFO.
writedata_left  out  DW  DAC left sample.
writedata_right  out  DW  DAC right sample.
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
overrun_count  out  16  samples dropped because the FIFO was full; saturates.
underrun_count  out  16  RUN-state drains that found the FIFO empty; saturates.

Behaviour:
- Reset (async, any time, including mid-transfer): state=IDLE, FIFO pointers and level=0, both counters=0. read=0 and write=0 while reset is high. writedata=0.
- read and write are single-cycle combinational qualifications of read_ready/write_ready. Each high cycle equals exactly one transfer.
- FSM states: IDLE, FILL, RUN.
- IDLE: read=0, write=0. Goes to FILL when enable=1.
- FILL:
  - read = read_ready.
  - write = write_ready, with writedata=0 (silence keeps the DAC fed).
  - Goes to RUN on the cycle after the registered level reaches PRIME or more.
- RUN:
  - read = read_ready.
  - write = write_ready.
  - If FIFO is non-empty, writedata = FIFO head, or 0 if mute=1. The write pops the FIFO.
  - If FIFO is empty and write_ready=1: write a zero sample, increment underrun_count, go to FILL.
- enable=0 in FILL or RUN: next cycle state=IDLE and FIFO flushed (level=0). Counters are kept. The current cycle's outputs still follow the current state.
- Push: read asserted and FIFO not full. The sample is written into FIFO memory at the clock edge and is visible at the head from the next cycle (1-cycle latency).
- Full on read: read is still asserted so the codec FIFO keeps moving. The sample is discarded and overrun_count increments.
- Push and pop in the same cycle: level unchanged. When full, pop plus push is a legal transfer, not an overrun.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Level is computed with one extra bit.
- Counters saturate at 16'hFFFF; no wrap.
- mute does not affect FSM transitions, the counters, or the FIFO.

Decomposition:
- Package audio_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, FILL, RUN} seq_state_t.
  - typedef struct packed {logic [DW-1:0] left, right;} stereo_t, with DW=24 as a package localparam.
  - COUNT_MAX = 16'hFFFF.
- Sub-module stereo_fifo (DEPTH parameter) provides push, pop, flush, full, empty, level and head; it is asynchronously reset.
- The sequencer contains only the FSM, the gating logic and the counters.

Test Plan:
- Reset mid-stream: assert reset with level=5 in RUN. Same cycle: read=write=0. After release: state IDLE, level=0, counters 0.
- Prime: enable=1 with read_ready pulsed 4 times and write_ready=1 throughout. During FILL, write carries zeros. Cycle after level=4, state=RUN. The next write carries the first captured sample (for example 24'h123456/24'hABCDEF).
- Overrun: write_ready=0 and 10 read_ready pulses with DEPTH=8. Expect level=8, overrun_count=2, and read asserted on all 10 pulses.
- Underrun: in RUN with level=1, two write_ready cycles. First write outputs the stored sample. Second outputs 0, underrun_count=1, state returns to FILL.
- Simultaneous push/pop at full: level=8, read_ready=write_ready=1 in RUN. Level stays 8, overrun_count unchanged, head advances in order.
- Mute and disable: mute=1 in RUN gives writedata=0 while level decrements per write. Then enable=0 gives IDLE next cycle, level=0, counters retained.
